// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO with a valid/ready push port.
// Frames are sent LSB-first, back-to-back while bytes remain queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  localparam int CNT_W      = $clog2(BIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         r_bit;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         r_sr;
  logic [7:0]         w_sr_nxt;
  logic               r_tx;
  logic               w_line;
  logic               w_last;
  logic               w_pop;
  logic               w_push;
  logic               w_nonempty;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [CW-1:0]      r_count;

  assign o_ready      = (r_count != CW'(FIFO_DEPTH));
  assign w_push       = i_valid & o_ready;
  assign w_nonempty   = (r_count != '0);
  assign w_last       = (r_cnt == CNT_W'(BIT_CYCLES - 1));
  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE) | w_nonempty;
  assign o_fifo_count = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_sr_nxt    = r_sr;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_sr_nxt    = r_mem[r_rd];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_last) begin
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_line = r_sr[0];
        if (w_last) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_sr_nxt  = r_sr >> 1;
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_line = 1'b1;
        if (w_last) begin
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_sr_nxt    = r_mem[r_rd];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The line level of the current state is registered, so o_tx trails the
  // state by one clock: a pop at edge N+1 shows the start bit from edge N+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_tx    <= 1'b1;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_sr    <= w_sr_nxt;
      r_tx    <= w_line;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model checked every clock,
// a line decoder comparing received bytes, a vector table and corner sequences.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 8;
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int FL       = 10 * BC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic [3:0] o_fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_fifo_count (o_fifo_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes plus the remaining length of the frame on the line.
  logic [7:0] mq[$];
  int         frame_left = 0;
  logic [9:0] cur_frame  = '1;
  logic       exp_tx     = 1'b1;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  int         hs_cnt = 0;
  int         peak   = 0;

  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = '0;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_ready;
    int         e_count;
    logic       e_busy;
    logic       e_tx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic       do_pop;
    logic       do_push;
    logic [7:0] b;
    if (r) begin
      if (frame_left > 0) void'(sent_q.pop_back());
      mq.delete();
      frame_left = 0;
      exp_tx     = 1'b1;
    end else begin
      do_pop  = (frame_left <= 1) && (mq.size() > 0);
      do_push = v && (mq.size() != DEPTH);
      if (frame_left == 0) exp_tx = 1'b1;
      else                 exp_tx = cur_frame[(FL - frame_left) / BC];
      if (do_pop) begin
        b          = mq.pop_front();
        cur_frame  = {1'b1, b, 1'b0};
        sent_q.push_back(b);
        frame_left = FL;
      end else if (frame_left > 0) begin
        frame_left--;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst     = r;
    i_valid = v;
    i_data  = d;
    #1;
    if (v && !r && o_ready) hs_cnt++;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    chk("tx",    int'(o_tx),         int'(exp_tx));
    chk("count", int'(o_fifo_count), mq.size());
    chk("ready", int'(o_ready),      int'(mq.size() != DEPTH));
    chk("busy",  int'(o_busy),       int'((frame_left > 0) || (mq.size() > 0)));
    if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
    if (r) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (o_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
        rx_byte[(rx_cnt - 15) / 10] = o_tx;
      if (rx_cnt == 95) begin
        chk("stop_bit", int'(o_tx), 1);
        rx_q.push_back(rx_byte);
      end
      if (rx_cnt == FL - 1) rx_active = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((frame_left > 0 || mq.size() > 0) && guard < 20000) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    chk("drain_done", int'(frame_left == 0 && mq.size() == 0), 1);
    idle(3);
  endtask

  task automatic wait_frame_left(input int target, input bit need_full);
    int guard;
    guard = 0;
    while (!(frame_left == target && (!need_full || mq.size() == DEPTH)) && guard < 2000) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    chk("wait_point", int'(frame_left == target), 1);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] hello[6];
    int         pushes;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 8'h41, 1'b1, 1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h42, 1'b1, 1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h43, 1'b1, 2, 1'b1, 1'b0};

    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d);
      chk("vec_ready", int'(o_ready),      int'(vecs[i].e_ready));
      chk("vec_count", int'(o_fifo_count), vecs[i].e_count);
      chk("vec_busy",  int'(o_busy),       int'(vecs[i].e_busy));
      chk("vec_tx",    int'(o_tx),         int'(vecs[i].e_tx));
    end
    drain();

    // Single 0x41 frame: exact bit pattern at mid-bit and busy release
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h41);
    pat = {1'b1, 8'h41, 1'b0};
    for (int m = 1; m <= 115; m++) begin
      step(1'b0, 1'b0, 8'h00);
      if (m >= 7 && m <= 97 && ((m - 7) % 10) == 0)
        chk("frame41_bit", int'(o_tx), int'(pat[(m - 7) / 10]));
      if (m == 2)   chk("frame41_start", int'(o_tx), 0);
      if (m == 100) chk("frame41_busy", int'(o_busy), 1);
      if (m == 110) chk("frame41_done", int'(o_busy), 0);
    end

    // "HELLO" + 0x72 back-to-back
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
    hello[3] = 8'h4C; hello[4] = 8'h4F; hello[5] = 8'h72;
    peak = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, hello[i]);
    chk("hello_peak", peak, 5);
    drain();

    // Hold valid 12 cycles while a frame is in flight
    step(1'b0, 1'b1, 8'hA5);
    idle(20);
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(i));
    chk("burst_accepted", hs_cnt, DEPTH);
    chk("burst_ready_low", int'(o_ready), 0);
    drain();

    // Reset at cnt=4 of data bit 3 with 3 bytes queued
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i));
    wait_frame_left(FL - (BC + 3 * BC + 4), 1'b0);
    chk("rst_queued", int'(o_fifo_count), 3);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_count", int'(o_fifo_count), 0);
    chk("rst_busy", int'(o_busy), 0);
    idle(250);

    // Fill the FIFO, then push on the cycle STOP pops
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
    chk("fill_full", int'(o_fifo_count), DEPTH);
    wait_frame_left(1, 1'b1);
    step(1'b0, 1'b1, 8'hEE);
    chk("pop_full_push", int'(o_fifo_count), DEPTH - 1);
    step(1'b0, 1'b1, 8'hEF);
    chk("refill", int'(o_fifo_count), DEPTH);
    drain();

    // Long idle after reset
    step(1'b1, 1'b0, 8'h00);
    idle(1000);

    // Randomised traffic
    for (int i = 0; i < 2500; i++)
      step(1'b0, 1'b1 ? ($urandom_range(0, 99) < 4) : 1'b0, 8'($urandom));
    drain();

    chk("rx_frames", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      chk("rx_byte", int'(rx_q[i]), int'(sent_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
